// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op encodings, FSM states,
// lane widths and small op-classification helpers.
package mem_lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } lsu_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  // Byte offset after force-alignment: word ops ignore addr[1:0], halfword ops ignore addr[0].
  function automatic logic [1:0] lane_off(input logic [2:0] op, input logic [1:0] a);
    logic [1:0] off;
    off = a;
    if (is_word(op)) off = 2'b00;
    else if (is_half(op)) off = {a[1], 1'b0};
    return off;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    return (is_word(op) && (a != 2'b00)) || (is_half(op) && a[0]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends a loaded byte/halfword and
// merges store data into a previously read word (little-endian lanes).
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = 32'd0;
    case (op)
      OP_LB:  load_data = {{(32-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      OP_LH:  load_data = {{(32-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      OP_LW:  load_data = rdata;
      OP_LBU: load_data = {{(32-BYTE_W){1'b0}}, byte_sel};
      OP_LHU: load_data = {{(32-HALF_W){1'b0}}, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged = rdata;
    case (op)
      OP_SB: begin
        case (off)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = rdata;
        endcase
      end
      OP_SH: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      OP_SW: merged = wdata;
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a word-addressed ram.
// Optional MEM_LSU_ALIGN_TRAP_EN: reject misaligned accesses instead of force-aligning.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_raddr,
  output logic [31:0] ram_waddr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready is a registered copy of "state is IDLE" and rsp_valid is a one-cycle
  // pulse that the pipeline must take (no response backpressure).

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  lsu_state_t  state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        out_range;
  logic        bad_align;
  logic        reject;
  logic [31:0] widx;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign dbg_state = state;
  assign accept    = req_valid && req_ready;
  assign out_range = (req_addr >= ADDR_LIMIT);
`ifdef MEM_LSU_ALIGN_TRAP_EN
  assign bad_align = misaligned(req_op, req_addr[1:0]);
`else
  assign bad_align = 1'b0;
`endif
  assign reject    = out_range || bad_align;
  assign widx      = {2'b00, req_addr[31:2]};

  mem_lane_align u_align (
    .op        (op_q),
    .off       (off_q),
    .rdata     (ram_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_LB;
      off_q     <= 2'b00;
      wdata_q   <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 32'd0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_raddr <= 32'd0;
      ram_waddr <= 32'd0;
      ram_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            off_q     <= lane_off(req_op, req_addr[1:0]);
            wdata_q   <= req_wdata;
            if (reject) begin
              state     <= ST_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
            end else if (req_op == OP_SW) begin
              state     <= ST_WR;
              ram_we    <= 1'b1;
              ram_waddr <= widx;
              ram_wdata <= req_wdata;
            end else begin
              state     <= ST_RD;
              ram_re    <= 1'b1;
              ram_raddr <= widx;
            end
          end
        end
        ST_RD: begin
          ram_re <= 1'b0;
          if (is_store(op_q)) begin
            state     <= ST_WR;
            ram_we    <= 1'b1;
            ram_waddr <= ram_raddr;
            ram_wdata <= merged;
          end else begin
            state     <= ST_RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= load_data;
          end
        end
        ST_WR: begin
          // Address and data stay put through RSP so the level-sensitive write settles.
          ram_we    <= 1'b0;
          state     <= ST_RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= 32'd0;
        end
        ST_RSP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= 32'd0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a word-addressed ram model and hand-computed expectations.
module tb_mem_lsu;

  localparam int DEPTH = 2048;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_raddr;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  logic        r_re;
  logic        r_we;
  logic        r_both;
  logic [31:0] r_waddr;

  mem_lsu #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_raddr (ram_raddr),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ram model: combinational read, write on rising edge while enabled
  assign ram_rdata = mem[ram_raddr[10:0]];
  always @(posedge clk) if (ram_we) mem[ram_waddr[10:0]] <= ram_wdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch up to 8 cycles for its response.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_val("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    r_data = 32'hXXXX_XXXX; r_err = 1'bx; r_lat = 0;
    r_re = 1'b0; r_we = 1'b0; r_both = 1'b0; r_waddr = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_re) r_re = 1'b1;
      if (ram_we) begin r_we = 1'b1; r_waddr = ram_waddr; end
      if (ram_re && ram_we) r_both = 1'b1;
      if (rsp_valid) begin
        r_lat  = k;
        r_data = rsp_data;
        r_err  = rsp_err;
        break;
      end
    end
    check_val("re_we_exclusive", {31'd0, r_both}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    mem[DEPTH-1] = 32'h1122_3344;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready",     {31'd0, req_ready}, 32'd1);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check_val("rst_rsp_data",  rsp_data,           32'd0);
    check_val("rst_ram_re",    {31'd0, ram_re},    32'd0);
    check_val("rst_ram_we",    {31'd0, ram_we},    32'd0);
    check_val("rst_raddr",     ram_raddr,          32'd0);
    check_val("rst_waddr",     ram_waddr,          32'd0);
    check_val("rst_wdata",     ram_wdata,          32'd0);
    check_val("rst_state",     {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    do_req(3'd7, 32'h10, 32'hDEAD_BEEF);
    check_val("sw_lat",   r_lat,           32'd2);
    check_val("sw_err",   {31'd0, r_err},  32'd0);
    check_val("sw_data",  r_data,          32'd0);
    check_val("sw_waddr", r_waddr,         32'd4);
    check_val("sw_mem",   mem[4],          32'hDEAD_BEEF);

    do_req(3'd2, 32'h10, 32'd0);
    check_val("lw_lat",  r_lat,          32'd2);
    check_val("lw_data", r_data,         32'hDEAD_BEEF);
    check_val("lw_re",   {31'd0, r_re},  32'd1);
    check_val("lw_no_we",{31'd0, r_we},  32'd0);

    do_req(3'd5, 32'h11, 32'h0000_00AA);
    check_val("sb_lat", r_lat,  32'd3);
    check_val("sb_mem", mem[4], 32'hDEAD_AAEF);
    do_req(3'd0, 32'h11, 32'd0);
    check_val("lb_data", r_data, 32'hFFFF_FFAA);
    do_req(3'd3, 32'h11, 32'd0);
    check_val("lbu_data", r_data, 32'h0000_00AA);

    do_req(3'd6, 32'h10, 32'h0000_8001);
    check_val("sh_lat", r_lat,  32'd3);
    check_val("sh_mem", mem[4], 32'hDEAD_8001);
    do_req(3'd1, 32'h10, 32'd0);
    check_val("lh_data", r_data, 32'hFFFF_8001);
    do_req(3'd4, 32'h10, 32'd0);
    check_val("lhu_data", r_data, 32'h0000_8001);
    do_req(3'd1, 32'h12, 32'd0);
    check_val("lh_upper", r_data, 32'hFFFF_DEAD);
    do_req(3'd4, 32'h12, 32'd0);
    check_val("lhu_upper", r_data, 32'h0000_DEAD);

    do_req(3'd2, 32'h13, 32'd0);
`ifdef MEM_LSU_ALIGN_TRAP_EN
    check_val("lw_mis_err",  {31'd0, r_err}, 32'd1);
    check_val("lw_mis_data", r_data,         32'd0);
    check_val("lw_mis_re",   {31'd0, r_re},  32'd0);
    check_val("lw_mis_lat",  r_lat,          32'd1);
`else
    check_val("lw_mis_err",  {31'd0, r_err}, 32'd0);
    check_val("lw_mis_data", r_data,         32'hDEAD_8001);
    check_val("lw_mis_lat",  r_lat,          32'd2);
`endif

    do_req(3'd6, 32'h13, 32'h0000_1234);
`ifdef MEM_LSU_ALIGN_TRAP_EN
    check_val("sh_mis_err", {31'd0, r_err}, 32'd1);
    check_val("sh_mis_we",  {31'd0, r_we},  32'd0);
    check_val("sh_mis_mem", mem[4],         32'hDEAD_8001);
`else
    check_val("sh_mis_err", {31'd0, r_err}, 32'd0);
    check_val("sh_mis_mem", mem[4],         32'h1234_8001);
    mem[4] = 32'hDEAD_8001;
`endif

    do_req(3'd2, 32'h2000, 32'd0);
    check_val("oor_err",  {31'd0, r_err}, 32'd1);
    check_val("oor_data", r_data,         32'd0);
    check_val("oor_lat",  r_lat,          32'd1);
    check_val("oor_re",   {31'd0, r_re},  32'd0);
    check_val("oor_we",   {31'd0, r_we},  32'd0);

    do_req(3'd7, 32'h2000, 32'h0BAD_0BAD);
    check_val("oor_sw_err", {31'd0, r_err}, 32'd1);
    check_val("oor_sw_we",  {31'd0, r_we},  32'd0);

    do_req(3'd5, 32'h1FFF, 32'h0000_005A);
    check_val("sb_top_err", {31'd0, r_err}, 32'd0);
    check_val("sb_top_mem", mem[DEPTH-1],   32'h5A22_3344);
    do_req(3'd0, 32'h1FFF, 32'd0);
    check_val("lb_top_data", r_data, 32'h0000_005A);

    // reset while an SB is in its read cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h11; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_val("rst_mid_in_rd", {31'd0, ram_re}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_mid_we",    {31'd0, ram_we},    32'd0);
    check_val("rst_mid_re",    {31'd0, ram_re},    32'd0);
    r_we = 1'b0; r_lat = 0;
    for (int k = 0; k < 5; k++) begin
      if (ram_we) r_we = 1'b1;
      if (rsp_valid) r_lat = r_lat + 1;
      @(negedge clk);
    end
    check_val("rst_mid_no_we",  {31'd0, r_we}, 32'd0);
    check_val("rst_mid_no_rsp", r_lat,         32'd0);
    check_val("rst_mid_mem",    mem[4],        32'hDEAD_8001);

    do_req(3'd2, 32'h10, 32'd0);
    check_val("post_rst_lw", r_data, 32'hDEAD_8001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
